// File: rtl/brick_collision_unit_pkg.sv
// Shared brick-field geometry, starting health table and controller states for the breakout
// brick collision logic.
package breakout_pkg;

    localparam int ANCHOR_LEFT = 2;
    localparam int ANCHOR_TOP  = 4;
    localparam int PITCH_X     = 20;
    localparam int PITCH_Y     = 12;
    localparam int BRICK_W     = 16;
    localparam int BRICK_H     = 8;
    localparam int N_COLS      = 8;
    localparam int N_ROWS      = 4;
    localparam int N_BRICKS    = N_COLS * N_ROWS;

    // Starting health by row: entry 0 is the top row.
    localparam logic [N_ROWS-1:0][2:0] ROW_HEALTH = {3'd1, 3'd2, 3'd3, 3'd4};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SCAN,
        ST_RESOLVE,
        ST_REPORT
    } state_t;

    function automatic logic [7:0] brick_left(input logic [2:0] col);
        return 8'(ANCHOR_LEFT + PITCH_X * int'(col));
    endfunction

    function automatic logic [7:0] brick_top(input logic [1:0] row);
        return 8'(ANCHOR_TOP + PITCH_Y * int'(row));
    endfunction

    function automatic logic [2:0] row_health(input logic [1:0] row);
        return ROW_HEALTH[row];
    endfunction

endpackage

// File: rtl/brick_collision_unit_if.sv
// Update request and hit/bounce result bundle between the ball logic, the renderer and the
// collision unit.
interface brick_collision_unit_if;
    logic       update_br;
    logic [7:0] X_IN;
    logic [7:0] Y_IN;
    logic       BOUNCE_LEFT;
    logic       BOUNCE_RIGHT;
    logic       BOUNCE_UP;
    logic       BOUNCE_DOWN;
    logic [7:0] COLLISION_X_OUT;
    logic [7:0] COLLISION_Y_OUT;
    logic       HIT_VALID;
    logic [4:0] HIT_INDEX;
    logic [2:0] HIT_HEALTH;
    logic [5:0] BRICKS_LEFT;
    logic       CLEARED;
    logic       BUSY;
    logic       DONE;

    modport master (
        output update_br, X_IN, Y_IN,
        input  BOUNCE_LEFT, BOUNCE_RIGHT, BOUNCE_UP, BOUNCE_DOWN,
        input  COLLISION_X_OUT, COLLISION_Y_OUT, HIT_VALID, HIT_INDEX, HIT_HEALTH,
        input  BRICKS_LEFT, CLEARED, BUSY, DONE
    );

    modport slave (
        input  update_br, X_IN, Y_IN,
        output BOUNCE_LEFT, BOUNCE_RIGHT, BOUNCE_UP, BOUNCE_DOWN,
        output COLLISION_X_OUT, COLLISION_Y_OUT, HIT_VALID, HIT_INDEX, HIT_HEALTH,
        output BRICKS_LEFT, CLEARED, BUSY, DONE
    );
endinterface

// File: rtl/brick_collision_unit_hit_test.sv
// Combinational overlap test of one brick against the ball box, plus the struck face derived
// from where the ball was on the previous update.
module brick_hit_test
    import breakout_pkg::*;
(
    input  logic [4:0] brick_idx,
    input  logic [8:0] ball_x0,
    input  logic [8:0] ball_x1,
    input  logic [8:0] ball_y0,
    input  logic [8:0] ball_y1,
    input  logic [8:0] prev_x0,
    input  logic [8:0] prev_x1,
    input  logic [8:0] prev_y0,
    input  logic [8:0] prev_y1,
    output logic       overlap,
    output logic       face_up,
    output logic       face_down,
    output logic       face_left,
    output logic       face_right
);
    logic [8:0] edge_l, edge_r, edge_t, edge_b;
    logic       prev_x_ov, prev_y_ov, vert, horiz;

    assign edge_l = {1'b0, brick_left(brick_idx[2:0])};
    assign edge_t = {1'b0, brick_top(brick_idx[4:3])};
    assign edge_r = edge_l + 9'(BRICK_W - 1);
    assign edge_b = edge_t + 9'(BRICK_H - 1);

    assign overlap = (ball_x1 >= edge_l) && (ball_x0 <= edge_r) &&
                     (ball_y1 >= edge_t) && (ball_y0 <= edge_b);

    assign prev_x_ov = (prev_x1 >= edge_l) && (prev_x0 <= edge_r);
    assign prev_y_ov = (prev_y1 >= edge_t) && (prev_y0 <= edge_b);

    // Column overlap wins over row overlap; with neither, the corner was struck on both axes.
    assign vert  = prev_x_ov || !prev_y_ov;
    assign horiz = !prev_x_ov;

    assign face_up    = vert  && (prev_y1 < edge_t);
    assign face_down  = vert  && !(prev_y1 < edge_t);
    assign face_left  = horiz && (prev_x1 < edge_l);
    assign face_right = horiz && !(prev_x1 < edge_l);
endmodule

// File: rtl/brick_collision_unit.sv
// Brick collision controller: latches the ball on update_br, scans all bricks for the first
// overlap, decrements its health and reports bounce direction and hit details.
module brick_collision_unit
    import breakout_pkg::*;
#(
    parameter int BALL_SIZE = 2
) (
    input  logic                    CLOCK_50,
    input  logic                    RESETN,
    brick_collision_unit_if.slave   bif
);
    state_t     state;
    logic [4:0] scan_idx, hit_idx, test_idx;
    logic       hit_found;
    logic [7:0] cur_x, cur_y, prev_x, prev_y;
    logic       prev_valid, have_cur;
    logic [2:0] health [N_BRICKS];
    logic [5:0] bricks_left;
    logic [3:0] face_q;
    logic       bounce_up, bounce_down, bounce_left, bounce_right;
    logic [7:0] coll_x, coll_y;
    logic       hit_valid, busy, done;
    logic [4:0] hit_index;
    logic [2:0] hit_health;

    logic [8:0] ball_x0, ball_x1, ball_y0, ball_y1;
    logic [8:0] prev_x0, prev_x1, prev_y0, prev_y1;
    logic       overlap, f_up, f_down, f_left, f_right, brick_hit;

    assign ball_x0 = {1'b0, cur_x};
    assign ball_y0 = {1'b0, cur_y};
    assign ball_x1 = ball_x0 + 9'(BALL_SIZE - 1);
    assign ball_y1 = ball_y0 + 9'(BALL_SIZE - 1);
    assign prev_x0 = {1'b0, prev_x};
    assign prev_y0 = {1'b0, prev_y};
    assign prev_x1 = prev_x0 + 9'(BALL_SIZE - 1);
    assign prev_y1 = prev_y0 + 9'(BALL_SIZE - 1);

    // The single tester walks the scan, then is pointed at the captured brick to resolve the face.
    assign test_idx  = (state == ST_RESOLVE) ? hit_idx : scan_idx;
    assign brick_hit = overlap && (health[test_idx] != 3'd0);

    brick_hit_test u_hit_test (
        .brick_idx  (test_idx),
        .ball_x0    (ball_x0),
        .ball_x1    (ball_x1),
        .ball_y0    (ball_y0),
        .ball_y1    (ball_y1),
        .prev_x0    (prev_x0),
        .prev_x1    (prev_x1),
        .prev_y0    (prev_y0),
        .prev_y1    (prev_y1),
        .overlap    (overlap),
        .face_up    (f_up),
        .face_down  (f_down),
        .face_left  (f_left),
        .face_right (f_right)
    );

    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            state        <= ST_IDLE;
            scan_idx     <= '0;
            hit_idx      <= '0;
            hit_found    <= 1'b0;
            cur_x        <= '0;
            cur_y        <= '0;
            prev_x       <= '0;
            prev_y       <= '0;
            prev_valid   <= 1'b0;
            have_cur     <= 1'b0;
            bricks_left  <= 6'(N_BRICKS);
            face_q       <= '0;
            bounce_up    <= 1'b0;
            bounce_down  <= 1'b0;
            bounce_left  <= 1'b0;
            bounce_right <= 1'b0;
            coll_x       <= '0;
            coll_y       <= '0;
            hit_valid    <= 1'b0;
            hit_index    <= '0;
            hit_health   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            for (int i = 0; i < N_BRICKS; i++) begin
                health[i] <= row_health(2'(i >> 3));
            end
        end else begin
            done         <= 1'b0;
            hit_valid    <= 1'b0;
            bounce_up    <= 1'b0;
            bounce_down  <= 1'b0;
            bounce_left  <= 1'b0;
            bounce_right <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bif.update_br) begin
                        busy  <= 1'b1;
                        state <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    prev_x     <= cur_x;
                    prev_y     <= cur_y;
                    prev_valid <= have_cur;
                    have_cur   <= 1'b1;
                    cur_x      <= bif.X_IN;
                    cur_y      <= bif.Y_IN;
                    hit_found  <= 1'b0;
                    scan_idx   <= '0;
                    state      <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (brick_hit && !hit_found) begin
                        hit_found <= 1'b1;
                        hit_idx   <= scan_idx;
                    end
                    if (scan_idx == 5'(N_BRICKS - 1)) state <= ST_RESOLVE;
                    else                              scan_idx <= scan_idx + 5'd1;
                end
                ST_RESOLVE: begin
                    if (hit_found) begin
                        health[hit_idx] <= health[hit_idx] - 3'd1;
                        if (health[hit_idx] == 3'd1) bricks_left <= bricks_left - 6'd1;
                        // No earlier position to compare against: assume the ball came from below.
                        face_q <= prev_valid ? {f_up, f_down, f_left, f_right} : 4'b0100;
                    end
                    busy  <= 1'b0;
                    state <= ST_REPORT;
                end
                ST_REPORT: begin
                    done <= 1'b1;
                    if (hit_found) begin
                        hit_valid    <= 1'b1;
                        bounce_up    <= face_q[3];
                        bounce_down  <= face_q[2];
                        bounce_left  <= face_q[1];
                        bounce_right <= face_q[0];
                        coll_x       <= brick_left(hit_idx[2:0]);
                        coll_y       <= brick_top(hit_idx[4:3]);
                        hit_index    <= hit_idx;
                        hit_health   <= health[hit_idx];
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bif.BOUNCE_UP       = bounce_up;
    assign bif.BOUNCE_DOWN     = bounce_down;
    assign bif.BOUNCE_LEFT     = bounce_left;
    assign bif.BOUNCE_RIGHT    = bounce_right;
    assign bif.COLLISION_X_OUT = coll_x;
    assign bif.COLLISION_Y_OUT = coll_y;
    assign bif.HIT_VALID       = hit_valid;
    assign bif.HIT_INDEX       = hit_index;
    assign bif.HIT_HEALTH      = hit_health;
    assign bif.BRICKS_LEFT     = bricks_left;
    assign bif.CLEARED         = (bricks_left == 6'd0);
    assign bif.BUSY            = busy;
    assign bif.DONE            = done;
endmodule
